icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache that replaces the flat instruction ROM in front of the processor's fetch stage. Hits return the instruction combinationally in the same cycle. A miss stalls the core and refills one full line from a backing instruction memory over a word-per-beat request/valid handshake. A flush input invalidates every line.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_refill_fsm.sv | 91 +++++++++
 rtl/icache_dm.sv | 112 +++++++++++
 tb/tb_icache_dm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared state type and address-split width helpers for the direct-mapped icache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: owns state, beat counter, latched line address, mem_* outputs
// and the flush-seen flag; drives write enables for the arrays held in the top.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W         = calc_off_w(WORDS_PER_LINE),
  localparam int LINE_W        = ADDR_W - OFF_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              miss_i,
  input  logic [LINE_W-1:0] line_addr_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  output state_e            state_o,
  output logic [OFF_W-1:0]  beat_o,
  output logic [LINE_W-1:0] line_o,
  output logic              data_we_o,
  output logic              tag_we_o,
  output logic              valid_set_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [OFF_W-1:0]  r_beat;
  logic [LINE_W-1:0] r_line;
  logic              r_flush_seen;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (miss_i) w_state_nxt = REFILL;
      REFILL:  if (mem_valid_i && (r_beat == LAST_BEAT)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat wraps to zero exactly when the last word lands, so it is clean for the next miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat       <= '0;
      r_line       <= '0;
      r_flush_seen <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_flush_seen <= 1'b0;
        if (miss_i) r_line <= line_addr_i;
      end else begin
        r_flush_seen <= r_flush_seen | flush_i;
      end
      if ((r_state == REFILL) && mem_valid_i) r_beat <= r_beat + OFF_W'(1);
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    data_we_o   = 1'b0;
    tag_we_o    = 1'b0;
    valid_set_o = 1'b0;
    case (r_state)
      REFILL: begin
        mem_req_o = 1'b1;
        data_we_o = mem_valid_i;
      end
      DONE: begin
        tag_we_o    = 1'b1;
        valid_set_o = ~r_flush_seen & ~flush_i;
      end
      default: ;
    endcase
  end

  assign mem_addr_o = {r_line, r_beat, 2'b00};
  assign state_o    = r_state;
  assign beat_o     = r_beat;
  assign line_o     = r_line;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with combinational hits and word-per-beat line refill.
// Define ICACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              hit_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_valid_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
  localparam int IDX_W  = calc_idx_w(LINES);
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int LINE_W = ADDR_W - OFF_W - 2;

  logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINES-1:0]  r_valid;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_miss;
  state_e            w_state;
  logic [OFF_W-1:0]  w_beat;
  logic [LINE_W-1:0] w_line;
  logic              w_data_we;
  logic              w_tag_we;
  logic              w_valid_set;
  logic              w_unused;

  assign w_off    = addr_i[OFF_W+1:2];
  assign w_idx    = addr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag    = addr_i[ADDR_W-1:OFF_W+IDX_W+2];
  assign w_unused = ^addr_i[1:0];

  assign hit_o   = (w_state == IDLE) && req_i && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign stall_o = (w_state != IDLE) || (req_i && !hit_o);
  assign w_miss  = (w_state == IDLE) && req_i && !hit_o;
  assign inst_o  = r_data[w_idx][w_off];

  icache_refill_fsm #(
    .ADDR_W         (ADDR_W),
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .miss_i      (w_miss),
    .line_addr_i (addr_i[ADDR_W-1:OFF_W+2]),
    .flush_i     (flush_i),
    .mem_valid_i (mem_valid_i),
    .state_o     (w_state),
    .beat_o      (w_beat),
    .line_o      (w_line),
    .data_we_o   (w_data_we),
    .tag_we_o    (w_tag_we),
    .valid_set_o (w_valid_set),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o)
  );

  always_ff @(posedge clk_i) begin
    if (w_data_we) r_data[w_line[IDX_W-1:0]][w_beat] <= mem_rdata_i;
    if (w_tag_we)  r_tag[w_line[IDX_W-1:0]]          <= w_line[LINE_W-1:IDX_W];
  end

  // Flush has priority over the DONE-cycle valid set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_valid <= '0;
    else if (flush_i)     r_valid <= '0;
    else if (w_valid_set) r_valid[w_line[IDX_W-1:0]] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (hit_o)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized fetches against a line-level
// model of which line base address each cache index currently holds.
module tb_icache_dm;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] inst_o;
  logic              hit_o;
  logic              stall_o;
  logic              flush_i = 1'b0;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_valid_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          m_valid [LINES];
  int unsigned m_base  [LINES];
  int unsigned m_hits;
  int unsigned m_misses;
  logic [31:0] seed;

  icache_dm #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .inst_o      (inst_o),
    .hit_o       (hit_o),
    .stall_o     (stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_valid_i (mem_valid_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Backing memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ seed ^ {w[15:0], w[31:16]};
  endfunction

  function automatic int unsigned line_of(input int unsigned a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic int idx_of(input int unsigned a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic bit model_hit(input int unsigned a);
    return m_valid[idx_of(a)] && (m_base[idx_of(a)] == line_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one fetch attempt. A miss is followed through the whole refill, checking
  // every cycle; flush_beat in 0..WPL-1 pulses flush on that beat, WPL pulses it in DONE.
  task automatic fetch(input int unsigned a, input int min_w, input int max_w,
                       input int flush_beat, output bit was_hit);
    int unsigned base;
    bit          exp_hit;
    int          nw;
    exp_hit = model_hit(a);
    base    = line_of(a);
    req_i   = 1'b1;
    addr_i  = a;
    @(negedge clk_i);
    check("req_hit", 32'(hit_o), 32'(exp_hit));
    check("req_stall", 32'(stall_o), 32'(!exp_hit));
    check("req_mem_req", 32'(mem_req_o), 32'd0);
    if (exp_hit) begin
      check("inst", inst_o, mem_word(a));
      m_hits++;
    end else begin
      m_misses++;
    end
    was_hit = exp_hit;
    @(posedge clk_i); #1;
    if (exp_hit) begin
      req_i = 1'b0;
    end else begin
      for (int b = 0; b < WPL; b++) begin
        nw = int'($urandom_range(max_w, min_w));
        for (int w = 0; w <= nw; w++) begin
          mem_valid_i = (w == nw);
          mem_rdata_i = (w == nw) ? mem_word(base + 4 * b) : $urandom;
          flush_i     = (w == nw) && (b == flush_beat);
          @(negedge clk_i);
          check("refill_mem_req", 32'(mem_req_o), 32'd1);
          check("refill_mem_addr", mem_addr_o, base + 4 * b);
          check("refill_stall", 32'(stall_o), 32'd1);
          check("refill_hit", 32'(hit_o), 32'd0);
          @(posedge clk_i); #1;
        end
      end
      mem_valid_i = 1'b0;
      flush_i     = (flush_beat == WPL);
      @(negedge clk_i);
      check("done_stall", 32'(stall_o), 32'd1);
      check("done_mem_req", 32'(mem_req_o), 32'd0);
      check("done_hit", 32'(hit_o), 32'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      if (flush_beat >= 0) begin
        model_clear();
      end else begin
        m_valid[idx_of(a)] = 1'b1;
        m_base[idx_of(a)]  = base;
      end
    end
  endtask

  // Driver: fetch with retries until the core gets its instruction, then maybe an idle gap.
  task automatic access(input int unsigned a, input int min_w, input int max_w, input int flush_beat);
    bit h;
    int fb;
    fb = flush_beat;
    for (int t = 0; t < 3; t++) begin
      fetch(a, min_w, max_w, fb, h);
      fb = -1;
      if (h) break;
    end
    if ($urandom_range(1, 0) == 1) begin
      @(negedge clk_i);
      check("idle_stall", 32'(stall_o), 32'd0);
      check("idle_hit", 32'(hit_o), 32'd0);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    model_clear();
  endtask

  initial begin
    bit h;
    int unsigned a;
    seed     = $urandom;
    m_hits   = 0;
    m_misses = 0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_hit", 32'(hit_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Cold miss, hit within same line, conflict eviction
    access(32'h40, 0, 0, -1);
    access(32'h48, 0, 0, -1);
    access(32'h140, 0, 0, -1);
    access(32'h40, 0, 0, -1);

    // Wait states of 3 cycles before each beat
    access(32'h84, 3, 3, -1);
    access(32'h8C, 0, 0, -1);

    // Flush after fill, then flush during second refill beat and during DONE
    do_flush();
    access(32'h40, 0, 0, -1);
    access(32'hC0, 0, 1, 1);
    access(32'hD0, 0, 0, WPL);

    // Reset asserted in the third refill beat
    do_flush();
    req_i  = 1'b1;
    addr_i = 32'h40;
    @(posedge clk_i); #1;
    for (int b = 0; b < 2; b++) begin
      mem_valid_i = 1'b1;
      mem_rdata_i = mem_word(32'h40 + 4 * b);
      @(posedge clk_i); #1;
    end
    mem_valid_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_mem_addr", mem_addr_o, 32'h48);
    rst_ni = 1'b0;
    req_i  = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req_o), 32'd0);
    check("async_rst_mem_addr", mem_addr_o, 32'd0);
    check("async_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni   = 1'b1;
    m_hits   = 0;
    m_misses = 0;
    model_clear();

    // Counter sequence: 0x40 miss, 0x44 hit, 0x140 miss, 0x40 miss, 0x4C hit
    access(32'h40, 0, 0, -1);
    access(32'h44, 0, 0, -1);
    access(32'h140, 0, 0, -1);
    access(32'h40, 0, 0, -1);
    access(32'h4C, 0, 0, -1);
`ifdef ICACHE_STATS_EN
    check("seq_miss_cnt", miss_cnt_o, 32'd3);
    check("seq_hit_cnt", hit_cnt_o, m_hits);
`endif

    // Randomized fetches over three tags per index
    for (int n = 0; n < 150; n++) begin
      a = $urandom_range(47, 0) * LINE_BYTES + $urandom_range(WPL - 1, 0) * 4 + $urandom_range(3, 0);
      if ($urandom_range(19, 0) == 0) do_flush();
      if ($urandom_range(9, 0) == 0) access(a, 0, 2, int'($urandom_range(WPL, 0)));
      else                           access(a, 0, 2, -1);
    end
    fetch(32'h0, 0, 0, -1, h);
    req_i = 1'b0;
`ifdef ICACHE_STATS_EN
    check("final_hit_cnt", hit_cnt_o, m_hits);
    check("final_miss_cnt", miss_cnt_o, m_misses);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
